// File: rtl/dac_spi_tx.sv
// Serial transmitter for a multi-channel DAC: sends {channel, code} MSB first
// inside a cs_n window, with a programmable sclk divider and idle polarity.
module dac_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 16,
  parameter int CH_W    = 2,
  parameter bit CPOL    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              sdo,
  output logic              done,
  output logic              busy
);

  localparam int FRAME_W = CH_W + DATA_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  logic div_tc;
  logic lead_edge;
  logic accept;

  assign div_tc    = (div_q == DIV_LAST);
  // A toggle while sclk sits at its idle level moves it away: a sampling edge.
  assign lead_edge = (sclk_q == CPOL);
  assign accept    = in_valid && ready_q;

  // Next-state logic.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (div_tc) state_d = SHIFT;
      SHIFT:   if (div_tc && !lead_edge && (bit_q == BIT_LAST)) state_d = HOLD;
      HOLD:    if (div_tc) state_d = GAP;
      GAP:     if (div_tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    div_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;

    if ((state_q != IDLE) && !div_tc) div_d = div_q + 1'b1;

    if (accept) begin
      shift_d = {in_ch, in_data};
      bit_d   = '0;
    end

    if ((state_q == SHIFT) && div_tc) begin
      sclk_d = ~sclk_q;
      // sdo advances with the trailing edge, except after the last bit.
      if (!lead_edge && (bit_q != BIT_LAST)) begin
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        bit_d   = bit_q + 1'b1;
      end
    end

    if (state_d == GAP) shift_d = '0;

    cs_n_d  = !(state_d inside {SETUP, SHIFT, HOLD});
    done_d  = (state_q == HOLD) && (state_d == GAP);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset wins over any accept on the same edge.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= CPOL;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready = ready_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign sdo      = shift_q[FRAME_W-1];
  assign done     = done_q;
  assign busy     = busy_q;

endmodule
